// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: captures a parallel word on start and shifts it out
// MSB-first, optionally repeating with a programmable idle gap until stopped.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     start,
  input  logic [WIDTH-1:0]         data,
  input  logic                     repeat_en,
  input  logic                     stop,
  output logic                     x,
  output logic                     x_valid,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               S,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND   = 2'b01,
    GAP_ST = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] pat;
  logic             rep;
  logic             stop_req;
  logic [GW-1:0]    gap_cnt;

  logic done_next;
  logic load;
  logic reload;
  logic shift;
  logic gap_load;
  logic last;

  assign last = (bit_idx == IW'(WIDTH - 1));

  // start is a one-edge request honoured only in IDLE; stop is sampled only in
  // SEND (latched, current word completes) and GAP (immediate exit).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      done     <= 1'b0;
      bit_idx  <= '0;
      stop_req <= 1'b0;
      gap_cnt  <= '0;
      shreg    <= '0;
      pat      <= '0;
      rep      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (load) begin
        shreg    <= data;
        pat      <= data;
        rep      <= repeat_en;
        stop_req <= 1'b0;
        bit_idx  <= '0;
      end else if (reload) begin
        shreg   <= pat;
        bit_idx <= '0;
      end else if (shift) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        bit_idx <= last ? '0 : bit_idx + 1'b1;
      end
      if (state == SEND && stop) stop_req <= 1'b1;
      if (gap_load) gap_cnt <= GW'(GAP - 1);
      else if (state == GAP_ST && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    load       = 1'b0;
    reload     = 1'b0;
    shift      = 1'b0;
    gap_load   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          load       = 1'b1;
        end
      end
      SEND: begin
        shift = 1'b1;
        if (last) begin
          if (rep && !stop_req && !stop) begin
            if (GAP > 0) begin
              state_next = GAP_ST;
              gap_load   = 1'b1;
            end else begin
              reload = 1'b1;
            end
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      GAP_ST: begin
        if (stop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (gap_cnt == '0) begin
          state_next = SEND;
          reload     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    x       = (state == SEND) ? shreg[WIDTH-1] : 1'b0;
    x_valid = (state == SEND);
    busy    = (state != IDLE);
    S       = state;
  end

endmodule
